apb_master_param: RTL and testbench

Parametrised APB master bridging CPU LOAD/STORE requests to an APB bus with NUM_SLV one-hot slave selects. Request address, data and direction are registered at capture and held stable for the whole transfer. The block stalls the CPU until completion and adds slave-error reporting, address-decode errors and a wait-state timeout. It sits between the core's data-memory port and the APB interconnect.

---
 rtl/apb_pkg.sv | 36 +++
 rtl/apb_timeout_cnt.sv | 44 ++++
 rtl/apb_master_param.sv | 159 +++++++++++++++
 tb/tb_apb_master_param.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the parametrised APB master.
//   apb_state_t : master FSM states
//   DEF_*       : default width / sizing constants used as parameter defaults
//   onehot_sel  : slave index -> one-hot select (MAX_SLV wide, caller truncates)
//   sel_width   : slave-index field width for a given slave count (min 1)
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DERR   = 2'd3
    } apb_state_t;

    localparam int unsigned DEF_CPU_AW      = 16;
    localparam int unsigned DEF_DW          = 16;
    localparam int unsigned DEF_PAW         = 10;
    localparam int unsigned DEF_NUM_SLV     = 4;
    localparam int unsigned DEF_SEL_LSB     = 10;
    localparam int unsigned DEF_TIMEOUT_CYC = 16;

    localparam int unsigned MAX_SLV   = 16;
    localparam int unsigned IDX_W_MAX = 4;

    function automatic logic [MAX_SLV-1:0] onehot_sel(input logic [IDX_W_MAX-1:0] idx);
        logic [MAX_SLV-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Wait-state counter for the APB master.
//   clk, rst : clock and synchronous active-high reset
//   clr      : clear the count (asserted while the transfer is in SETUP)
//   en       : count one wait cycle
//   tc       : count has reached TIMEOUT_CYC-1; constant 0 when TIMEOUT_CYC == 0
module apb_timeout_cnt
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The master leaves ACCESS on terminal count, so the counter never needs
    // to saturate; with the timeout disabled it may wrap harmlessly.
    assign tc = (TIMEOUT_CYC != 0) && (cnt_q == TC_VAL);

endmodule

// File: rtl/apb_master_param.sv
// APB master bridging a stalling CPU LOAD/STORE port onto an APB bus.
//   clock, reset          : system clock, synchronous active-high reset
//   req_valid/write/addr/wdata : CPU request, held until block_pc falls
//   block_pc              : CPU stall
//   rsp_valid/rdata/err   : one-cycle completion with read data and error flag
//   err_addr              : sticky address of the last errored request
//   pclk, preset          : copies of clock / reset for the APB side
//   paddr/psel/penable/pwrite/pwdata : APB request outputs
//   prdata/pready/pslverr : muxed APB slave response
module apb_master_param
    import apb_pkg::*;
#(
    parameter int unsigned    CPU_AW      = DEF_CPU_AW,
    parameter int unsigned    DW          = DEF_DW,
    parameter int unsigned    PAW         = DEF_PAW,
    parameter int unsigned    NUM_SLV     = DEF_NUM_SLV,
    parameter int unsigned    SEL_LSB     = DEF_SEL_LSB,
    parameter int unsigned    TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter logic [DW-1:0]  ERR_DATA    = DW'(16'hDEAD)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    input  logic                req_write,
    input  logic [CPU_AW-1:0]   req_addr,
    input  logic [DW-1:0]       req_wdata,
    output logic                block_pc,
    output logic                rsp_valid,
    output logic [DW-1:0]       rsp_rdata,
    output logic                rsp_err,
    output logic [CPU_AW-1:0]   err_addr,
    output logic                pclk,
    output logic                preset,
    output logic [PAW-1:0]      paddr,
    output logic [NUM_SLV-1:0]  psel,
    output logic                penable,
    output logic                pwrite,
    output logic [DW-1:0]       pwdata,
    input  logic [DW-1:0]       prdata,
    input  logic                pready,
    input  logic                pslverr
);

    localparam int unsigned SEL_W = sel_width(NUM_SLV);

    apb_state_t          state_q, state_d;
    logic [CPU_AW-1:0]   cap_addr_q, cap_addr_d;
    logic [DW-1:0]       cap_wdata_q, cap_wdata_d;
    logic                cap_write_q, cap_write_d;
    logic [SEL_W-1:0]    cap_idx_q, cap_idx_d;
    logic [CPU_AW-1:0]   err_addr_q, err_addr_d;

    logic [SEL_W-1:0]    req_idx;
    logic                to_tc;

    assign pclk     = clock;
    assign preset   = reset;
    assign err_addr = err_addr_q;
    assign req_idx  = req_addr[SEL_LSB +: SEL_W];

    apb_timeout_cnt #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk (clock),
        .rst (reset),
        .clr (state_q == SETUP),
        .en  ((state_q == ACCESS) && !pready),
        .tc  (to_tc)
    );

    always_comb begin
        state_d     = state_q;
        cap_addr_d  = cap_addr_q;
        cap_wdata_d = cap_wdata_q;
        cap_write_d = cap_write_q;
        cap_idx_d   = cap_idx_q;
        err_addr_d  = err_addr_q;

        block_pc  = 1'b0;
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_rdata = '0;
        psel      = '0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = '0;
        pwdata    = '0;

        // APB request outputs come straight from the capture registers so they
        // cannot follow req_* once the transfer has started.
        if ((state_q == SETUP) || (state_q == ACCESS)) begin
            psel    = NUM_SLV'(onehot_sel(IDX_W_MAX'(cap_idx_q)));
            penable = (state_q == ACCESS);
            pwrite  = cap_write_q;
            paddr   = cap_addr_q[PAW-1:0];
            pwdata  = cap_write_q ? cap_wdata_q : '0;
        end

        unique case (state_q)
            IDLE: begin
                block_pc = req_valid;
                if (req_valid) begin
                    cap_addr_d  = req_addr;
                    cap_wdata_d = req_wdata;
                    cap_write_d = req_write;
                    cap_idx_d   = req_idx;
                    state_d     = (32'(req_idx) < NUM_SLV) ? SETUP : DERR;
                end
            end
            SETUP: begin
                block_pc = 1'b1;
                state_d  = ACCESS;
            end
            ACCESS: begin
                // pready wins over a coincident timeout.
                if (pready || to_tc) begin
                    rsp_valid = 1'b1;
                    rsp_err   = pready ? pslverr : 1'b1;
                    rsp_rdata = cap_write_q ? '0 : (rsp_err ? ERR_DATA : prdata);
                    if (rsp_err) begin
                        err_addr_d = cap_addr_q;
                    end
                    state_d = IDLE;
                end else begin
                    block_pc = 1'b1;
                end
            end
            DERR: begin
                rsp_valid  = 1'b1;
                rsp_err    = 1'b1;
                rsp_rdata  = cap_write_q ? '0 : ERR_DATA;
                err_addr_d = cap_addr_q;
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_write_q <= 1'b0;
            cap_idx_q   <= '0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cap_addr_q  <= cap_addr_d;
            cap_wdata_q <= cap_wdata_d;
            cap_write_q <= cap_write_d;
            cap_idx_q   <= cap_idx_d;
            err_addr_q  <= err_addr_d;
        end
    end

endmodule

// File: tb/tb_apb_master_param.sv
module tb_apb_master_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_write;
    logic [15:0] req_addr, req_wdata;
    logic [15:0] prdata;
    logic        pready, pslverr;

    // Instance A: 4 slaves, 4-cycle timeout. Instance B: 3 slaves, no timeout.
    logic        a_block_pc, a_rsp_valid, a_rsp_err, a_pclk, a_preset, a_penable, a_pwrite;
    logic [15:0] a_rsp_rdata, a_err_addr, a_pwdata;
    logic [9:0]  a_paddr;
    logic [3:0]  a_psel;
    logic        b_block_pc, b_rsp_valid, b_rsp_err, b_pclk, b_preset, b_penable, b_pwrite;
    logic [15:0] b_rsp_rdata, b_err_addr, b_pwdata;
    logic [9:0]  b_paddr;
    logic [2:0]  b_psel;

    always #5 clock = ~clock;

    apb_master_param #(.NUM_SLV(4), .TIMEOUT_CYC(4)) dut_a (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .block_pc(a_block_pc),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
        .err_addr(a_err_addr), .pclk(a_pclk), .preset(a_preset), .paddr(a_paddr),
        .psel(a_psel), .penable(a_penable), .pwrite(a_pwrite), .pwdata(a_pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr));

    apb_master_param #(.NUM_SLV(3), .TIMEOUT_CYC(0)) dut_b (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .block_pc(b_block_pc),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .err_addr(b_err_addr), .pclk(b_pclk), .preset(b_preset), .paddr(b_paddr),
        .psel(b_psel), .penable(b_penable), .pwrite(b_pwrite), .pwdata(b_pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr));

    // Both instances see the same stimulus; use_b picks which one is checked.
    bit          use_b;
    logic        o_block_pc, o_rsp_valid, o_rsp_err, o_penable, o_pwrite;
    logic [15:0] o_rsp_rdata, o_err_addr, o_pwdata;
    logic [9:0]  o_paddr;
    logic [3:0]  o_psel;

    always_comb begin
        o_block_pc  = use_b ? b_block_pc  : a_block_pc;
        o_rsp_valid = use_b ? b_rsp_valid : a_rsp_valid;
        o_rsp_err   = use_b ? b_rsp_err   : a_rsp_err;
        o_rsp_rdata = use_b ? b_rsp_rdata : a_rsp_rdata;
        o_err_addr  = use_b ? b_err_addr  : a_err_addr;
        o_penable   = use_b ? b_penable   : a_penable;
        o_pwrite    = use_b ? b_pwrite    : a_pwrite;
        o_pwdata    = use_b ? b_pwdata    : a_pwdata;
        o_paddr     = use_b ? b_paddr     : a_paddr;
        o_psel      = use_b ? {1'b0, b_psel} : a_psel;
    end

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [15:0] exp_err_addr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut %s): got %0h expected %0h", nm, use_b ? "B" : "A", act, exp);
        end
    endtask

    // Reference model: spec-level rules for one request on the selected instance.
    function automatic int unsigned slave_of(input logic [15:0] addr);
        return (32'(addr) >> 10) % 4;
    endfunction

    function automatic int unsigned nslv();
        return use_b ? 3 : 4;
    endfunction

    function automatic void model(input bit wr, input logic [15:0] addr, input int unsigned w,
                                  input bit se, input logic [15:0] rd,
                                  output int unsigned k, output bit err, output logic [15:0] erd);
        int unsigned t;
        t = use_b ? 0 : 4;
        if (slave_of(addr) >= nslv()) begin
            k = 1; err = 1'b1;
        end else if (t != 0 && w >= t) begin
            k = 1 + t; err = 1'b1;
        end else begin
            k = 2 + w; err = se;
        end
        erd = wr ? 16'h0 : (err ? 16'hDEAD : rd);
    endfunction

    // One request: cycle 0 is the capture cycle, the response is expected at cycle k.
    // The slave raises pready on cycle 2+w (w wait states).
    task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                           input int unsigned w, input bit se, input logic [15:0] rd, input bit chg,
                           input int unsigned k, input bit err, input logic [15:0] erd);
        int unsigned idx;
        bit derr, act;
        idx  = slave_of(addr);
        derr = (idx >= nslv());
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        for (int unsigned c = 0; c <= k; c++) begin
            if (chg && c >= 1) begin
                req_addr = 16'($urandom); req_wdata = 16'($urandom); req_write = 1'($urandom);
            end
            pready  = !derr && (c == 2 + w);
            pslverr = (c == 2 + w) ? se : 1'($urandom);
            prdata  = (c == 2 + w) ? rd : 16'($urandom);
            #3;
            act = !derr && (c >= 1);
            chk("block_pc",  32'(o_block_pc),  32'(c < k));
            chk("rsp_valid", 32'(o_rsp_valid), 32'(c == k));
            chk("psel",      32'(o_psel),      act ? (32'd1 << idx) : 32'd0);
            chk("penable",   32'(o_penable),   32'(act && c >= 2));
            chk("paddr",     32'(o_paddr),     act ? 32'(addr[9:0]) : 32'd0);
            chk("pwrite",    32'(o_pwrite),    32'(act && wr));
            chk("pwdata",    32'(o_pwdata),    (act && wr) ? 32'(wd) : 32'd0);
            if (c == k) begin
                chk("rsp_err",   32'(o_rsp_err),   32'(err));
                chk("rsp_rdata", 32'(o_rsp_rdata), 32'(erd));
            end
            @(posedge clock); #1;
        end
        if (err) exp_err_addr = addr;
        req_valid = 1'b0; pready = 1'b0;
        #3;
        chk("err_addr",       32'(o_err_addr),  32'(exp_err_addr));
        chk("psel_after",     32'(o_psel),      32'd0);
        chk("rsp_valid_after", 32'(o_rsp_valid), 32'd0);
        chk("block_pc_after", 32'(o_block_pc),  32'd0);
        @(posedge clock); #1;
    endtask

    task automatic rand_txn();
        bit wr, se, chg, err;
        logic [15:0] addr, wd, rd, erd;
        int unsigned w, k;
        wr = 1'($urandom); se = ($urandom_range(0, 3) == 0); chg = 1'($urandom);
        addr = 16'($urandom); wd = 16'($urandom); rd = 16'($urandom);
        w = $urandom_range(0, 6);
        model(wr, addr, w, se, rd, k, err, erd);
        run_txn(wr, addr, wd, w, se, rd, chg, k, err, erd);
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_err_addr = '0;
    endtask

    typedef struct {
        bit          b;
        bit          wr;
        logic [15:0] addr;
        logic [15:0] wd;
        int unsigned w;
        bit          se;
        logic [15:0] rd;
        bit          chg;
        int unsigned k;
        bit          err;
        logic [15:0] erd;
    } vec_t;

    vec_t tv[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n_rsp, n_setup;

        //         b  wr addr      wdata    w  se rdata    chg k   err erd
        tv[0]  = '{0, 1, 16'h0405, 16'h1234, 0, 0, 16'h0000, 0, 2,  0, 16'h0000};
        tv[1]  = '{0, 0, 16'h0C10, 16'h0000, 3, 0, 16'hBEEF, 1, 5,  0, 16'hBEEF};
        tv[2]  = '{0, 0, 16'h0800, 16'h0000, 6, 0, 16'h0000, 0, 5,  1, 16'hDEAD};
        tv[3]  = '{0, 0, 16'h0400, 16'h0000, 3, 0, 16'h5A5A, 0, 5,  0, 16'h5A5A};
        tv[4]  = '{0, 0, 16'h0000, 16'h0000, 0, 1, 16'h1111, 0, 2,  1, 16'hDEAD};
        tv[5]  = '{0, 0, 16'h0C3F, 16'h0000, 1, 0, 16'h2222, 0, 3,  0, 16'h2222};
        tv[6]  = '{0, 1, 16'h08AA, 16'hFFFF, 2, 1, 16'h0000, 0, 4,  1, 16'h0000};
        tv[7]  = '{1, 0, 16'h0C00, 16'h0000, 0, 0, 16'h0000, 0, 1,  1, 16'hDEAD};
        tv[8]  = '{1, 1, 16'h0C02, 16'h4321, 0, 0, 16'h0000, 0, 1,  1, 16'h0000};
        tv[9]  = '{1, 0, 16'h0400, 16'h0000, 20, 0, 16'h7777, 0, 22, 0, 16'h7777};
        tv[10] = '{1, 0, 16'h0BFF, 16'h0000, 0, 0, 16'h0F0F, 0, 2,  0, 16'h0F0F};

        use_b = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        @(posedge clock); #1;
        do_reset();

        // Reset state of both instances.
        for (int i = 0; i < 2; i++) begin
            use_b = (i == 1);
            #1;
            chk("rst_psel",      32'(o_psel),      32'd0);
            chk("rst_penable",   32'(o_penable),   32'd0);
            chk("rst_paddr",     32'(o_paddr),     32'd0);
            chk("rst_pwrite",    32'(o_pwrite),    32'd0);
            chk("rst_pwdata",    32'(o_pwdata),    32'd0);
            chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
            chk("rst_rsp_err",   32'(o_rsp_err),   32'd0);
            chk("rst_rsp_rdata", 32'(o_rsp_rdata), 32'd0);
            chk("rst_err_addr",  32'(o_err_addr),  32'd0);
            chk("rst_block_pc",  32'(o_block_pc),  32'd0);
        end
        chk("pclk",   32'(a_pclk),   32'(clock));
        chk("preset", 32'(b_preset), 32'(reset));
        @(posedge clock); #1;
        use_b = 1'b0;

        // Directed vectors; the instances are reset when the checked one changes.
        for (int i = 0; i < 11; i++) begin
            if (tv[i].b != use_b) begin
                do_reset();
                use_b = tv[i].b;
            end
            run_txn(tv[i].wr, tv[i].addr, tv[i].wd, tv[i].w, tv[i].se, tv[i].rd, tv[i].chg,
                    tv[i].k, tv[i].err, tv[i].erd);
        end
        chk("b_err_addr_sticky", 32'(b_err_addr), 32'h0C02);

        // Held req_valid over 9 cycles: three captures, three responses, no duplicates.
        n_rsp = 0; n_setup = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0800;
        pready = 1'b1; prdata = 16'h3C3C; pslverr = 1'b0;
        for (int c = 0; c < 9; c++) begin
            #3;
            if (o_rsp_valid) n_rsp++;
            if (o_psel != 4'd0 && !o_penable) n_setup++;
            @(posedge clock); #1;
        end
        req_valid = 1'b0; pready = 1'b0;
        chk("hold_rsp_count",   n_rsp,   32'd3);
        chk("hold_setup_count", n_setup, 32'd3);
        @(posedge clock); #1;

        // Reset during ACCESS: next cycle idle, no response, err_addr cleared.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h0400; pready = 1'b0;
        repeat (2) begin @(posedge clock); #1; end
        #3;
        chk("pre_reset_penable", 32'(o_penable), 32'd1);
        reset = 1'b1; req_valid = 1'b0;
        @(posedge clock); #1;
        #3;
        chk("midrst_psel",      32'(o_psel),      32'd0);
        chk("midrst_penable",   32'(o_penable),   32'd0);
        chk("midrst_rsp_valid", 32'(o_rsp_valid), 32'd0);
        chk("midrst_err_addr",  32'(o_err_addr),  32'd0);
        reset = 1'b0;
        exp_err_addr = '0;
        @(posedge clock); #1;

        // Randomised traffic against the reference model on each instance.
        for (int i = 0; i < 2; i++) begin
            do_reset();
            use_b = (i == 1);
            for (int n = 0; n < 40; n++) rand_txn();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
